// File: rtl/pic_host_sequencer_if.sv
// CPU-side bus to the 8259A: chip strobes, A0, split data bus, INTA# and INT.
// The sequencer is the master; the PIC (or its model) is the slave.
interface pic_host_sequencer_if;
  logic       chip_select_n;
  logic       write_enable_n;
  logic       read_enable_n;
  logic       address;
  logic [7:0] data_bus_out;
  logic       data_bus_io;
  logic [7:0] data_bus_in;
  logic       interrupt_acknowledge_n;
  logic       interrupt_to_cpu;

  modport master (
    output chip_select_n, write_enable_n, read_enable_n, address,
           data_bus_out, data_bus_io, interrupt_acknowledge_n,
    input  data_bus_in, interrupt_to_cpu
  );

  modport slave (
    input  chip_select_n, write_enable_n, read_enable_n, address,
           data_bus_out, data_bus_io, interrupt_acknowledge_n,
    output data_bus_in, interrupt_to_cpu
  );
endinterface

// File: rtl/pic_host_sequencer.sv
// 8259A host sequencer: writes ICW1..ICW4 + OCW1 on request, then answers INT
// with an INTA# pulse train (2 pulses in 8086 mode, 3 in MCS-80 mode) and captures the vector bytes.
module pic_host_sequencer #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_init,
  input  logic [7:0]                  cfg_icw1,
  input  logic [7:0]                  cfg_icw2,
  input  logic [7:0]                  cfg_icw3,
  input  logic [7:0]                  cfg_icw4,
  input  logic [7:0]                  cfg_ocw1,
  input  logic                        ack_enable,
  pic_host_sequencer_if.master        pic,
  output logic [7:0]                  vector_byte0,
  output logic [7:0]                  vector_byte1,
  output logic [7:0]                  vector_byte2,
  output logic                        vector_valid,
  output logic                        busy,
  output logic                        init_done
);

  localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       WORD_NONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_GAP, ACK_STROBE, ACK_GAP, ACK_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       word_idx, word_idx_nxt;
  logic [1:0]       pulse_idx, pulse_idx_nxt;
  logic             init_done_nxt;
  logic             load_cfg;
  logic             capture;
  logic [2:0]       word_next;
  logic [1:0]       last_pulse;
  logic [7:0]       wr_data_nxt;
  logic [7:0]       data_q;
  logic             addr_q;
  logic [7:0]       icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q;

  // Word order is ICW1, ICW2, ICW3, ICW4, OCW1 (0..4); returns the next word
  // the latched ICW1 enables after idx, or WORD_NONE when the list is exhausted.
  function automatic logic [2:0] next_word_f(input logic [2:0] idx, input logic [7:0] icw1);
    logic [4:0] en;
    logic [2:0] nxt;
    en  = {1'b1, icw1[0], ~icw1[1], 1'b1, 1'b1};
    nxt = WORD_NONE;
    for (int i = 4; i >= 0; i--)
      if (3'(i) > idx && en[i]) nxt = 3'(i);
    return nxt;
  endfunction

  assign word_next  = next_word_f(word_idx, icw1_q);
  // ICW4 is only written when ICW1 asks for it, so 8086 mode needs both bits.
  assign last_pulse = (icw1_q[0] && icw4_q[0]) ? 2'd1 : 2'd2;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      word_idx  <= '0;
      pulse_idx <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      word_idx  <= word_idx_nxt;
      pulse_idx <= pulse_idx_nxt;
      init_done <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    word_idx_nxt  = word_idx;
    pulse_idx_nxt = pulse_idx;
    init_done_nxt = init_done;
    load_cfg      = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (start_init) begin
          state_nxt     = WR_SETUP;
          word_idx_nxt  = '0;
          cnt_nxt       = '0;
          load_cfg      = 1'b1;
          init_done_nxt = 1'b0;
        end else if (init_done && ack_enable && pic.interrupt_to_cpu) begin
          state_nxt     = ACK_STROBE;
          cnt_nxt       = STROBE_LOAD;
          pulse_idx_nxt = '0;
        end
      end
      WR_SETUP: begin
        state_nxt = WR_STROBE;
        cnt_nxt   = STROBE_LOAD;
      end
      WR_STROBE: begin
        if (cnt == '0) begin
          state_nxt = WR_GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WR_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (word_next == WORD_NONE) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          init_done_nxt = 1'b1;
        end else begin
          state_nxt    = WR_SETUP;
          cnt_nxt      = '0;
          word_idx_nxt = word_next;
        end
      end
      ACK_STROBE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ACK_GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ACK_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (pulse_idx == last_pulse) begin
          state_nxt = ACK_DONE;
          cnt_nxt   = '0;
        end else begin
          state_nxt     = ACK_STROBE;
          cnt_nxt       = STROBE_LOAD;
          pulse_idx_nxt = pulse_idx + 2'd1;
        end
      end
      ACK_DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first word comes straight from the inputs being latched on this edge.
  always_comb begin
    wr_data_nxt = cfg_icw1;
    if (!load_cfg) begin
      case (word_idx_nxt)
        3'd0:    wr_data_nxt = icw1_q;
        3'd1:    wr_data_nxt = icw2_q;
        3'd2:    wr_data_nxt = icw3_q;
        3'd3:    wr_data_nxt = icw4_q;
        default: wr_data_nxt = ocw1_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (load_cfg) begin
      icw1_q <= cfg_icw1;
      icw2_q <= cfg_icw2;
      icw3_q <= cfg_icw3;
      icw4_q <= cfg_icw4;
      ocw1_q <= cfg_ocw1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q       <= '0;
      addr_q       <= 1'b0;
      vector_byte0 <= '0;
      vector_byte1 <= '0;
      vector_byte2 <= '0;
    end else begin
      if (state_nxt == WR_SETUP) begin
        data_q <= wr_data_nxt;
        addr_q <= (word_idx_nxt != 3'd0);
      end
      if (capture) begin
        case (pulse_idx)
          2'd0:    vector_byte0 <= pic.data_bus_in;
          2'd1:    vector_byte1 <= pic.data_bus_in;
          default: vector_byte2 <= pic.data_bus_in;
        endcase
      end
    end
  end

  assign pic.chip_select_n           = !(state == WR_SETUP || state == WR_STROBE || state == WR_GAP);
  assign pic.write_enable_n          = (state != WR_STROBE);
  assign pic.read_enable_n           = 1'b1;
  assign pic.data_bus_io             = pic.chip_select_n;
  assign pic.interrupt_acknowledge_n = (state != ACK_STROBE);
  assign pic.address                 = addr_q;
  assign pic.data_bus_out            = data_q;
  assign vector_valid                = (state == ACK_DONE);
  assign busy                        = (state != IDLE);

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Bench for pic_host_sequencer: queued expected bus writes and vector captures,
// compared by a negedge bus monitor that also plays the PIC's INTA# responder.
module tb_pic_host_sequencer;
  localparam int S = 2;
  localparam int G = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_init = 1'b0;
  logic [7:0] cfg_icw1 = '0, cfg_icw2 = '0, cfg_icw3 = '0, cfg_icw4 = '0, cfg_ocw1 = '0;
  logic       ack_enable = 1'b0;
  logic [7:0] vector_byte0, vector_byte1, vector_byte2;
  logic       vector_valid, busy, init_done;

  pic_host_sequencer_if bus ();

  pic_host_sequencer #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .start_init(start_init),
    .cfg_icw1(cfg_icw1), .cfg_icw2(cfg_icw2), .cfg_icw3(cfg_icw3),
    .cfg_icw4(cfg_icw4), .cfg_ocw1(cfg_ocw1), .ack_enable(ack_enable),
    .pic(bus.master),
    .vector_byte0(vector_byte0), .vector_byte1(vector_byte1), .vector_byte2(vector_byte2),
    .vector_valid(vector_valid), .busy(busy), .init_done(init_done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0]  exp_wr_q[$];   // {A0, data}
  logic [25:0] exp_ack_q[$];  // {pulses, byte0, byte1, byte2}
  logic [7:0]  resp [3];
  int          inta_total = 0;
  int          ack_pulses = 0;

  // PIC-side monitor and INTA# data responder
  logic       wr_prev_low = 1'b0, inta_prev_low = 1'b0;
  int         wr_len = 0, inta_len = 0;
  logic [8:0] wr_seen;
  logic [8:0] e_wr;
  logic [25:0] e_ack;
  always @(negedge clock) begin
    if (reset) begin
      wr_prev_low      = 1'b0;
      inta_prev_low    = 1'b0;
      ack_pulses       = 0;
      bus.data_bus_in  = 8'h00;
    end else begin
      if (!bus.write_enable_n) begin
        if (!wr_prev_low) begin
          wr_seen = {bus.address, bus.data_bus_out};
          wr_len  = 0;
          chk("wr_cs_low", bus.chip_select_n, 1'b0);
          chk("wr_io_drive", bus.data_bus_io, 1'b0);
        end
        wr_len++;
      end else if (wr_prev_low) begin
        chk("wr_len", wr_len, S);
        chk("gap_cs_low", bus.chip_select_n, 1'b0);
        chk("gap_data_held", bus.data_bus_out, wr_seen[7:0]);
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e_wr = exp_wr_q.pop_front();
          chk("wr_a0", wr_seen[8], e_wr[8]);
          chk("wr_data", wr_seen[7:0], e_wr[7:0]);
        end
      end
      wr_prev_low = !bus.write_enable_n;

      if (!bus.interrupt_acknowledge_n) begin
        if (!inta_prev_low) begin
          ack_pulses++;
          inta_total++;
          inta_len = 0;
          bus.data_bus_in = resp[(ack_pulses - 1) % 3];
          chk("inta_cs_high", bus.chip_select_n, 1'b1);
          chk("inta_io_input", bus.data_bus_io, 1'b1);
        end
        inta_len++;
      end else if (inta_prev_low) begin
        chk("inta_len", inta_len, S);
      end
      inta_prev_low = !bus.interrupt_acknowledge_n;

      if (vector_valid) begin
        if (exp_ack_q.size() == 0) chk("vv_unexpected", 1, 0);
        else begin
          e_ack = exp_ack_q.pop_front();
          chk("ack_pulses", ack_pulses, e_ack[25:24]);
          chk("vec_b0", vector_byte0, e_ack[23:16]);
          chk("vec_b1", vector_byte1, e_ack[15:8]);
          chk("vec_b2", vector_byte2, e_ack[7:0]);
        end
        ack_pulses = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one start_init pulse and queues the writes the PIC should see.
  task automatic run_init(input logic [7:0] i1, i2, i3, i4, o1);
    cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw3 = i3; cfg_icw4 = i4; cfg_ocw1 = o1;
    exp_wr_q.push_back({1'b0, i1});
    exp_wr_q.push_back({1'b1, i2});
    if (!i1[1]) exp_wr_q.push_back({1'b1, i3});
    if (i1[0])  exp_wr_q.push_back({1'b1, i4});
    exp_wr_q.push_back({1'b1, o1});
    start_init = 1'b1;
    tick();
    start_init = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 200) begin tick(); n++; end
    chk(tag, init_done, 1'b1);
  endtask

  task automatic wait_vv(input string tag);
    int n;
    n = 0;
    while (!vector_valid && n < 200) begin tick(); n++; end
    chk(tag, vector_valid, 1'b1);
  endtask

  initial begin
    int base;
    int falls;
    logic prev;
    resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h00;
    bus.interrupt_to_cpu = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    chk("rst_cs_n", bus.chip_select_n, 1'b1);
    chk("rst_wr_n", bus.write_enable_n, 1'b1);
    chk("rst_rd_n", bus.read_enable_n, 1'b1);
    chk("rst_inta_n", bus.interrupt_acknowledge_n, 1'b1);
    chk("rst_io", bus.data_bus_io, 1'b1);
    chk("rst_a0", bus.address, 1'b0);
    chk("rst_data", bus.data_bus_out, 8'h00);
    chk("rst_flags", {busy, init_done, vector_valid}, 3'b000);
    chk("rst_vec", {vector_byte0, vector_byte1, vector_byte2}, 24'h0);

    // 1: 8086 single-PIC init, 4 writes, 16 clocks
    run_init(8'h13, 8'h20, 8'h55, 8'h01, 8'hFE);
    chk("t1_busy", busy, 1'b1);
    repeat (15) tick();
    chk("t1_done_early", init_done, 1'b0);
    tick();
    chk("t1_done_16", init_done, 1'b1);
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_wr_left", exp_wr_q.size(), 0);

    // 2: cascade with ICW4 (5 writes), then single without ICW4 (3 writes)
    run_init(8'h11, 8'h08, 8'h04, 8'h03, 8'hF0);
    chk("t2_done_cleared", init_done, 1'b0);
    wait_done("t2a_done");
    chk("t2a_wr_left", exp_wr_q.size(), 0);
    run_init(8'h12, 8'h30, 8'hAA, 8'hBB, 8'h7F);
    wait_done("t2b_done");
    tick();
    chk("t2b_wr_left", exp_wr_q.size(), 0);

    // 3: 8086 ack, two pulses, INT dropped mid-ack
    run_init(8'h13, 8'h20, 8'h00, 8'h01, 8'hFE);
    wait_done("t3_init");
    resp[0] = 8'h00; resp[1] = 8'h24; resp[2] = 8'h99;
    exp_ack_q.push_back({2'd2, 8'h00, 8'h24, 8'h00});
    base = inta_total;
    ack_enable = 1'b1;
    bus.interrupt_to_cpu = 1'b1;
    for (int i = 0; i < 50 && bus.interrupt_acknowledge_n; i++) tick();
    bus.interrupt_to_cpu = 1'b0;
    wait_vv("t3_vv");
    tick();
    chk("t3_vv_1clk", vector_valid, 1'b0);
    repeat (20) tick();
    chk("t3_pulses", inta_total - base, 2);
    chk("t3_ack_left", exp_ack_q.size(), 0);

    // 4: MCS-80 ack, three pulses
    run_init(8'h13, 8'h20, 8'h00, 8'h00, 8'hFE);
    wait_done("t4_init");
    resp[0] = 8'hCD; resp[1] = 8'h40; resp[2] = 8'h12;
    exp_ack_q.push_back({2'd3, 8'hCD, 8'h40, 8'h12});
    base = inta_total;
    bus.interrupt_to_cpu = 1'b1;
    wait_vv("t4_vv");
    bus.interrupt_to_cpu = 1'b0;
    repeat (10) tick();
    chk("t4_pulses", inta_total - base, 3);
    chk("t4_ack_left", exp_ack_q.size(), 0);

    // 5: reset during the second INTA# low
    resp[0] = 8'hCD; resp[1] = 8'h11; resp[2] = 8'h22;
    bus.interrupt_to_cpu = 1'b1;
    falls = 0;
    prev = 1'b1;
    for (int i = 0; i < 100 && falls < 2; i++) begin
      tick();
      if (!bus.interrupt_acknowledge_n && prev) falls++;
      prev = bus.interrupt_acknowledge_n;
    end
    chk("t5_reached_pulse2", falls, 2);
    reset = 1'b1;
    tick();
    chk("t5_inta_high", bus.interrupt_acknowledge_n, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_init_done", init_done, 1'b0);
    reset = 1'b0;
    base = inta_total;
    repeat (20) tick();
    chk("t5_int_ignored", inta_total - base, 0);

    // 6: start_init beats INT; start_init while busy ignored
    bus.interrupt_to_cpu = 1'b0;
    run_init(8'h13, 8'h20, 8'h00, 8'h01, 8'hFE);
    wait_done("t6_pre_init");
    base = inta_total;
    bus.interrupt_to_cpu = 1'b1;
    run_init(8'h13, 8'h21, 8'h00, 8'h01, 8'hFC);
    chk("t6_busy", busy, 1'b1);
    chk("t6_no_inta", bus.interrupt_acknowledge_n, 1'b1);
    chk("t6_done_cleared", init_done, 1'b0);
    tick();
    cfg_icw1 = 8'h11; cfg_icw2 = 8'h99; cfg_icw3 = 8'h77; cfg_icw4 = 8'h03; cfg_ocw1 = 8'h00;
    start_init = 1'b1;
    tick();
    start_init = 1'b0;
    bus.interrupt_to_cpu = 1'b0;
    wait_done("t6_done");
    repeat (5) tick();
    chk("t6_wr_left", exp_wr_q.size(), 0);
    chk("t6_pulses", inta_total - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
